// File: rtl/ibex_rf_burst_loader_pkg.sv
// ibex_rf_burst_loader_pkg: shared FSM states and sizing constants for the regfile burst loader.
package ibex_rf_burst_loader_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_e;
    localparam int unsigned BURST_WORDS = 4;
    localparam logic [5:0] TOP_ADDR = 6'd31;
    localparam logic [5:0] TOP_ADDR_E = 6'd15;
endpackage

// File: rtl/ibex_rf_burst_buf.sv
// ibex_rf_burst_buf: 4-slot word buffer filled in arrival order, with fill counter and clear.
module ibex_rf_burst_buf import ibex_rf_burst_loader_pkg::*; #(
    parameter int DataWidth = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clr_i,
    input  logic                                  wr_i,
    input  logic [DataWidth-1:0]                  data_i,
    output logic [BURST_WORDS-1:0][DataWidth-1:0] slot_o,
    output logic [2:0]                            cnt_o
);
    logic [BURST_WORDS-1:0][DataWidth-1:0] r_slot;
    logic [2:0]                            r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_slot <= '0;
            r_cnt  <= '0;
        end else if (wr_i && r_cnt < 3'(BURST_WORDS)) begin
            r_slot[r_cnt[1:0]] <= data_i;
            r_cnt              <= r_cnt + 3'd1;
        end
    end
    assign slot_o = r_slot;
    assign cnt_o  = r_cnt;
endmodule

// File: rtl/ibex_rf_burst_loader.sv
// ibex_rf_burst_loader: streams words into consecutive registers as bursts of up to 4,
// yielding to the core write port and validating each command's register range.
module ibex_rf_burst_loader import ibex_rf_burst_loader_pkg::*; #(
    parameter bit RV32E     = 1'b0,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [4:0]           cmd_addr_i,
    input  logic [4:0]           cmd_count_i,
    output logic                 cmd_err_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 abort_i,
    input  logic                 core_we_i,
    output logic                 rf_valid_o,
    output logic [4:0]           rf_addr_o,
    output logic [1:0]           rf_len_o,
    output logic [DataWidth-1:0] rf_data_o,
    output logic [DataWidth-1:0] rf_msg1_o,
    output logic [DataWidth-1:0] rf_msg2_o,
    output logic [DataWidth-1:0] rf_msg3_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam logic [5:0] TopAddr = RV32E ? TOP_ADDR_E : TOP_ADDR;

    state_e                                r_state, w_next;
    logic [4:0]                            r_base, r_rem;
    logic                                  r_cmd_err, r_busy, r_done, r_rf_valid;
    logic [4:0]                            r_rf_addr;
    logic [1:0]                            r_rf_len;
    logic [DataWidth-1:0]                  r_rf_data, r_rf_msg1, r_rf_msg2, r_rf_msg3;
    logic [BURST_WORDS-1:0][DataWidth-1:0] w_slot;
    logic [2:0]                            w_cnt, w_cnt_n;
    logic [4:0]                            w_rem_n;
    logic [5:0]                            w_cmd_end;
    logic                                  w_cmd_ok, w_accept, w_emit_due, w_fire;

    assign w_cmd_end  = {1'b0, cmd_addr_i} + {1'b0, cmd_count_i} - 6'd1;
    assign w_cmd_ok   = cmd_addr_i != '0 && cmd_count_i != '0 && w_cmd_end <= TopAddr;
    assign w_accept   = r_state == COLLECT && in_valid_i && !abort_i;
    assign w_cnt_n    = w_cnt + 3'd1;
    assign w_rem_n    = r_rem - 5'd1;
    // The crossing term guards the register-file top even if the count check is ever relaxed.
    assign w_emit_due = w_cnt_n == 3'(BURST_WORDS) || w_rem_n == '0 ||
                        ({1'b0, r_base} + {3'b0, w_cnt_n}) > TopAddr;
    assign w_fire     = r_state == EMIT && !core_we_i && !abort_i;

    ibex_rf_burst_buf #(.DataWidth(DataWidth)) u_buf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_fire || abort_i),
        .wr_i   (w_accept),
        .data_i (in_data_i),
        .slot_o (w_slot),
        .cnt_o  (w_cnt)
    );

    always_ff @(posedge clk_i) begin
        r_state <= rst_i ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort_i && r_state != IDLE) w_next = IDLE;
        else if (r_state == IDLE && cmd_valid_i && w_cmd_ok) w_next = COLLECT;
        else if (w_accept && w_emit_due) w_next = EMIT;
        else if (w_fire) w_next = (r_rem == '0) ? IDLE : COLLECT;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base     <= '0;
            r_rem      <= '0;
            r_cmd_err  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rf_valid <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_len   <= '0;
            r_rf_data  <= '0;
            r_rf_msg1  <= '0;
            r_rf_msg2  <= '0;
            r_rf_msg3  <= '0;
        end else begin
            r_cmd_err  <= r_state == IDLE && cmd_valid_i && !w_cmd_ok;
            r_busy     <= w_next != IDLE;
            r_rf_valid <= w_fire;
            r_done     <= w_fire && r_rem == '0;
            if (r_state == IDLE && cmd_valid_i && w_cmd_ok) begin
                r_base <= cmd_addr_i;
                r_rem  <= cmd_count_i;
            end
            if (w_accept) r_rem <= w_rem_n;
            if (w_fire) begin
                r_base    <= r_base + 5'(w_cnt);
                r_rf_addr <= r_base;
                r_rf_len  <= 2'(w_cnt - 3'd1);
                r_rf_data <= w_slot[0];
                r_rf_msg1 <= w_cnt > 3'd1 ? w_slot[1] : '0;
                r_rf_msg2 <= w_cnt > 3'd2 ? w_slot[2] : '0;
                r_rf_msg3 <= w_cnt > 3'd3 ? w_slot[3] : '0;
            end
        end
    end

    assign cmd_ready_o = r_state == IDLE;
    assign in_ready_o  = r_state == COLLECT;
    assign cmd_err_o   = r_cmd_err;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign rf_valid_o  = r_rf_valid;
    assign rf_addr_o   = r_rf_addr;
    assign rf_len_o    = r_rf_len;
    assign rf_data_o   = r_rf_data;
    assign rf_msg1_o   = r_rf_msg1;
    assign rf_msg2_o   = r_rf_msg2;
    assign rf_msg3_o   = r_rf_msg3;
endmodule

// File: tb/tb_ibex_rf_burst_loader.sv
// tb_ibex_rf_burst_loader: directed table of load commands plus hand-written stall/abort/reset sequences.
module tb_ibex_rf_burst_loader;
    localparam int DW = 32;

    logic          clk_i = 1'b0, rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0, in_valid_i = 1'b0, abort_i = 1'b0, core_we_i = 1'b0;
    logic [4:0]    cmd_addr_i = '0, cmd_count_i = '0;
    logic [DW-1:0] in_data_i = '0;
    logic          cmd_ready_o, cmd_err_o, in_ready_o, rf_valid_o, busy_o, done_o;
    logic [4:0]    rf_addr_o;
    logic [1:0]    rf_len_o;
    logic [DW-1:0] rf_data_o, rf_msg1_o, rf_msg2_o, rf_msg3_o;

    ibex_rf_burst_loader #(.RV32E(1'b0), .DataWidth(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_count_i(cmd_count_i), .cmd_err_o(cmd_err_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .abort_i(abort_i), .core_we_i(core_we_i),
        .rf_valid_o(rf_valid_o), .rf_addr_o(rf_addr_o), .rf_len_o(rf_len_o),
        .rf_data_o(rf_data_o), .rf_msg1_o(rf_msg1_o), .rf_msg2_o(rf_msg2_o),
        .rf_msg3_o(rf_msg3_o), .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct {
        logic [4:0]    addr;
        logic [1:0]    len;
        logic [DW-1:0] d [4];
        logic          done;
    } burst_t;

    typedef struct {
        logic [4:0] addr;
        logic [4:0] count;
        logic       exp_err;
        int         exp_nb;
    } vec_t;

    burst_t bq[$];
    int     n_err_pulse = 0, n_done = 0;
    int     n_tests = 0, n_fail = 0;

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rf_valid_o) bq.push_back('{rf_addr_o, rf_len_o, '{rf_data_o, rf_msg1_o, rf_msg2_o, rf_msg3_o}, done_o});
        if (cmd_err_o) n_err_pulse++;
        if (done_o) n_done++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    function automatic logic [DW-1:0] pat(input int tag, input int j);
        return DW'(tag * 65536 + j);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_cmd(input logic [4:0] a, input logic [4:0] c);
        int t = 0;
        while (!cmd_ready_o && t < 100) begin step(); t++; end
        chk("cmd_ready_wait", 64'(t < 100), 1);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = a;
        cmd_count_i = c;
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic feed_words(input int n, input int tag);
        for (int j = 0; j < n; j++) begin
            int t = 0;
            in_valid_i = 1'b1;
            in_data_i  = pat(tag, j);
            while (!in_ready_o && t < 50) begin step(); t++; end
            if (t >= 50) chk("feed_timeout", 64'(in_ready_o), 1);
            step();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_o && t < 100) begin step(); t++; end
        chk("idle_wait", 64'(busy_o), 0);
    endtask

    task automatic check_bursts(input int tag, input int a, input int c, input int nb);
        chk("n_bursts", 64'(bq.size()), 64'(nb));
        for (int b = 0; b < nb && b < bq.size(); b++) begin
            int rem = c - 4 * b;
            int len = (rem > 4 ? 4 : rem) - 1;
            chk("burst_addr", 64'(bq[b].addr), 64'(a + 4 * b));
            chk("burst_len", 64'(bq[b].len), 64'(len));
            for (int k = 0; k < 4; k++)
                chk("burst_word", 64'(bq[b].d[k]), k <= len ? 64'(pat(tag, 4 * b + k)) : 64'd0);
            chk("burst_done", 64'(bq[b].done), 64'(b == nb - 1));
        end
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{5'd5,  5'd4,  1'b0, 1};
        tbl[1]  = '{5'd2,  5'd6,  1'b0, 2};
        tbl[2]  = '{5'd30, 5'd2,  1'b0, 1};
        tbl[3]  = '{5'd31, 5'd2,  1'b1, 0};
        tbl[4]  = '{5'd0,  5'd3,  1'b1, 0};
        tbl[5]  = '{5'd7,  5'd0,  1'b1, 0};
        tbl[6]  = '{5'd1,  5'd31, 1'b0, 8};
        tbl[7]  = '{5'd28, 5'd4,  1'b0, 1};
        tbl[8]  = '{5'd29, 5'd4,  1'b1, 0};
        tbl[9]  = '{5'd31, 5'd1,  1'b0, 1};
        tbl[10] = '{5'd3,  5'd9,  1'b0, 3};

        repeat (2) step();
        chk("rst_rf_valid", 64'(rf_valid_o), 0);
        chk("rst_rf_addr", 64'(rf_addr_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_done", 64'(done_o), 0);
        chk("rst_cmd_err", 64'(cmd_err_o), 0);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 1);
        chk("rst_in_ready", 64'(in_ready_o), 0);
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            bq.delete();
            n_err_pulse = 0;
            n_done = 0;
            do_cmd(tbl[i].addr, tbl[i].count);
            if (!tbl[i].exp_err) feed_words(int'(tbl[i].count), i + 1);
            wait_idle();
            repeat (2) step();
            chk("err_pulses", 64'(n_err_pulse), 64'(tbl[i].exp_err));
            chk("done_pulses", 64'(n_done), tbl[i].exp_err ? 64'd0 : 64'd1);
            check_bursts(i + 1, int'(tbl[i].addr), int'(tbl[i].count), tbl[i].exp_nb);
        end

        // core write port stalls the burst for three cycles
        bq.delete();
        core_we_i = 1'b1;
        do_cmd(5'd12, 5'd2);
        feed_words(2, 50);
        chk("stall_in_ready", 64'(in_ready_o), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_rf_valid", 64'(rf_valid_o), 0);
            chk("stall_rf_addr", 64'(rf_addr_o), 11);
            chk("stall_rf_len", 64'(rf_len_o), 0);
            chk("stall_busy", 64'(busy_o), 1);
        end
        core_we_i = 1'b0;
        step();
        chk("stall_fire_valid", 64'(rf_valid_o), 1);
        chk("stall_fire_addr", 64'(rf_addr_o), 12);
        chk("stall_fire_len", 64'(rf_len_o), 1);
        chk("stall_fire_data", 64'(rf_data_o), 64'(pat(50, 0)));
        chk("stall_fire_msg1", 64'(rf_msg1_o), 64'(pat(50, 1)));
        chk("stall_fire_msg2", 64'(rf_msg2_o), 0);
        chk("stall_fire_done", 64'(done_o), 1);
        step();
        chk("stall_one_strobe", 64'(rf_valid_o), 0);
        wait_idle();
        chk("stall_n_bursts", 64'(bq.size()), 1);

        // abort mid-collect, then a fresh single-word command
        bq.delete();
        do_cmd(5'd20, 5'd4);
        feed_words(2, 60);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_cmd_ready", 64'(cmd_ready_o), 1);
        chk("abort_busy", 64'(busy_o), 0);
        chk("abort_rf_valid", 64'(rf_valid_o), 0);
        do_cmd(5'd10, 5'd1);
        feed_words(1, 61);
        wait_idle();
        repeat (2) step();
        chk("abort_n_bursts", 64'(bq.size()), 1);
        if (bq.size() > 0) begin
            chk("abort_next_addr", 64'(bq[0].addr), 10);
            chk("abort_next_len", 64'(bq[0].len), 0);
            chk("abort_next_data", 64'(bq[0].d[0]), 64'(pat(61, 0)));
            chk("abort_next_done", 64'(bq[0].done), 1);
        end

        // abort while a burst is waiting on the core
        bq.delete();
        n_done = 0;
        core_we_i = 1'b1;
        do_cmd(5'd4, 5'd2);
        feed_words(2, 62);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        core_we_i = 1'b0;
        repeat (3) step();
        chk("abort_emit_bursts", 64'(bq.size()), 0);
        chk("abort_emit_done", 64'(n_done), 0);
        chk("abort_emit_ready", 64'(cmd_ready_o), 1);

        // reset while a burst is held off by the core
        bq.delete();
        core_we_i = 1'b1;
        do_cmd(5'd8, 5'd3);
        feed_words(3, 63);
        rst_i = 1'b1;
        step();
        chk("rstemit_rf_valid", 64'(rf_valid_o), 0);
        chk("rstemit_rf_addr", 64'(rf_addr_o), 0);
        chk("rstemit_rf_len", 64'(rf_len_o), 0);
        chk("rstemit_rf_data", 64'(rf_data_o), 0);
        chk("rstemit_rf_msg1", 64'(rf_msg1_o), 0);
        chk("rstemit_busy", 64'(busy_o), 0);
        chk("rstemit_done", 64'(done_o), 0);
        chk("rstemit_cmd_ready", 64'(cmd_ready_o), 1);
        rst_i = 1'b0;
        core_we_i = 1'b0;
        repeat (3) step();
        chk("rstemit_bursts", 64'(bq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
